section_readout_arbiter: RTL

//  Round-robin read scheduler for the per-column memories of one ARCADIA section.
//  - Picks a non-empty, enabled column and drives a one-cycle pulse on its colmem_read line.
//  - Captures the returned colmem_out word and tags it with the column index.
//  - Pushes the tagged word into a small output FIFO with a valid/ready handshake toward the section serializer.

---
 rtl/section_readout_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/section_readout_arbiter.sv
// ---------------------------------------------------------------------------
// section_readout_arbiter
//
// Round-robin read scheduler for the per-column memories of one section.
// A non-empty, enabled column is picked each cycle and receives a one-cycle
// read pulse. The word returned one cycle later is tagged with its column
// index and pushed into a small first-word-fall-through output FIFO, which
// the section serializer drains through a valid/ready handshake.
//
// Ports
//   clock_i         section clock, all logic on the rising edge
//   reset_i         synchronous, active-high reset
//   enable_i        1: issue reads; 0: stop issuing, finish in-flight, drain
//   col_mask_i      1 = column excluded from arbitration
//   colmem_empty_i  per-column memory empty flag (lags a read by one cycle)
//   colmem_read_o   one-hot read pulse, registered
//   colmem_out_i    column memory data, valid the cycle after colmem_read_o
//   out_valid_o     FIFO head valid
//   out_ready_i     consumer takes the head when out_valid_o && out_ready_i
//   out_data_o      FIFO head word
//   out_col_o       column index of the head word
//   busy_o          FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module section_readout_arbiter #(
   parameter int COLUMNS    = 16,
   parameter int DATA_BITS  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           enable_i,
   input  logic [COLUMNS-1:0]             col_mask_i,
   input  logic [COLUMNS-1:0]             colmem_empty_i,
   output logic [COLUMNS-1:0]             colmem_read_o,
   input  logic [COLUMNS*DATA_BITS-1:0]   colmem_out_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [DATA_BITS-1:0]           out_data_o,
   output logic [$clog2(COLUMNS)-1:0]     out_col_o,
   output logic                           busy_o
);

   localparam int CW = $clog2(COLUMNS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0]   COLS_W   = (CW+1)'(COLUMNS);
   localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS-1);
   localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(FIFO_DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CW-1:0]           rr_ptr_q;
   logic [COLUMNS-1:0]      read_q;       // read pulse currently on the wires
   logic [CW-1:0]           read_col_q;   // column of that pulse
   logic                    cap_pend_q;   // colmem_out carries a word this cycle
   logic [CW-1:0]           cap_col_q;
   logic [DATA_BITS+CW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q;
   logic [AW-1:0]           rd_ptr_q;
   logic [AW:0]             count_q;

   logic [DATA_BITS-1:0]    col_word [COLUMNS];
   logic [COLUMNS-1:0]      req;
   logic [2*COLUMNS-1:0]    req_dbl;
   logic [CW:0]             gnt_off;
   logic [CW:0]             gnt_sum;
   logic                    gnt_any;
   logic [CW-1:0]           gnt_col;
   logic [CW-1:0]           rr_ptr_d;
   logic                    read_any;
   logic                    push;
   logic                    pop;
   logic                    issue;
   logic [AW+1:0]           occupancy;
   logic [DATA_BITS+CW-1:0] head;

   // A column that is being pulsed right now still shows its pre-read empty
   // flag, so it must sit out this grant decision.
   generate
      for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_col
         assign col_word[gi] = colmem_out_i[gi*DATA_BITS +: DATA_BITS];
         assign req[gi]      = ~colmem_empty_i[gi] & ~col_mask_i[gi] & ~read_q[gi];
      end
   endgenerate

   // Rotate so bit 0 is the column at rr_ptr; the lowest set bit then gives
   // the distance from rr_ptr to the winner, wrapping naturally.
   assign req_dbl = {req, req} >> rr_ptr_q;

   always_comb begin
      gnt_any = 1'b0;
      gnt_off = '0;
      for (int i = COLUMNS-1; i >= 0; i--) begin
         if (req_dbl[i]) begin
            gnt_any = 1'b1;
            gnt_off = (CW+1)'(i);
         end
      end
      gnt_sum  = {1'b0, rr_ptr_q} + gnt_off;
      gnt_col  = (gnt_sum >= COLS_W) ? CW'(gnt_sum - COLS_W) : CW'(gnt_sum);
      rr_ptr_d = (gnt_col == LAST_COL) ? '0 : gnt_col + CW'(1);
   end

   assign read_any = |read_q;
   assign push     = cap_pend_q;
   assign pop      = out_valid_o & out_ready_i;

   // Every word between its read pulse and its pop holds a FIFO slot, so a
   // read is only issued when the slot is guaranteed to exist at push time.
   assign occupancy = (AW+2)'(count_q) + (AW+2)'(read_any) + (AW+2)'(cap_pend_q);
   assign issue     = (state_q == RUN) && enable_i && gnt_any &&
                      (occupancy < DEPTH_W + (AW+2)'(pop));

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         read_q     <= '0;
         read_col_q <= '0;
         cap_pend_q <= 1'b0;
         cap_col_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         case (state_q)
            IDLE:    if (enable_i) state_q <= RUN;
            RUN:     if (!enable_i) state_q <= DRAIN;
            DRAIN: begin
               if (enable_i)
                  state_q <= RUN;
               else if (!read_any && !cap_pend_q && (count_q == '0))
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         read_q <= '0;
         if (issue) begin
            read_q[gnt_col] <= 1'b1;
            read_col_q      <= gnt_col;
            rr_ptr_q        <= rr_ptr_d;
         end

         cap_pend_q <= read_any;
         cap_col_q  <= read_col_q;

         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Storage has no reset; the pointers and count define what is valid.
   always_ff @(posedge clock_i) begin
      if (push) fifo_mem[wr_ptr_q] <= {cap_col_q, col_word[cap_col_q]};
   end

   // Head is read combinationally so the first word falls through.
   assign head          = fifo_mem[rd_ptr_q];
   assign out_valid_o   = (count_q != '0);
   assign out_data_o    = out_valid_o ? head[DATA_BITS-1:0] : '0;
   assign out_col_o     = out_valid_o ? head[DATA_BITS+CW-1:DATA_BITS] : '0;
   assign busy_o        = (state_q != IDLE) || out_valid_o;
   assign colmem_read_o = read_q;

   a_read_onehot: assert property (@(posedge clock_i) disable iff (reset_i)
      $onehot0(read_q));
   a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
      !(push && (count_q == FULL_CNT) && !pop));
   a_read_nonempty: assert property (@(posedge clock_i) disable iff (reset_i)
      ((read_q & colmem_empty_i) == '0));

endmodule
